// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store memory stage: RV32I access encodings and FSM states.
package mem_lsu_pkg;

   localparam logic [2:0] INST_LB  = 3'b000;
   localparam logic [2:0] INST_LH  = 3'b001;
   localparam logic [2:0] INST_LW  = 3'b010;
   localparam logic [2:0] INST_LBU = 3'b100;
   localparam logic [2:0] INST_LHU = 3'b101;
   localparam logic [2:0] INST_SB  = 3'b000;
   localparam logic [2:0] INST_SH  = 3'b001;
   localparam logic [2:0] INST_SW  = 3'b010;

   typedef enum logic [1:0] {StIdle, StReq, StResp} lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extraction/extension,
// and access legality flags.
module mem_lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [2:0]  func3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] ldata_o,
   output logic        misaligned_o,
   output logic        ld_illegal_o,
   output logic        st_illegal_o
);

   logic [31:0] lane;

   always_comb begin
      wdata_o = store_data_i;
      be_o    = 4'b1111;
      unique case (func3_i[1:0])
         2'b00: begin
            wdata_o = {4{store_data_i[7:0]}};
            be_o    = 4'b0001 << off_i;
         end
         2'b01: begin
            wdata_o = {2{store_data_i[15:0]}};
            be_o    = 4'b0011 << off_i;
         end
         default: ;
      endcase
   end

   assign lane = rdata_i >> {off_i, 3'b000};

   always_comb begin
      ldata_o = rdata_i;
      case (func3_i)
         INST_LB:  ldata_o = {{24{lane[7]}}, lane[7:0]};
         INST_LH:  ldata_o = {{16{lane[15]}}, lane[15:0]};
         INST_LBU: ldata_o = {24'h0, lane[7:0]};
         INST_LHU: ldata_o = {16'h0, lane[15:0]};
         default:  ldata_o = rdata_i;
      endcase
   end

   assign misaligned_o = ((func3_i[1:0] == 2'b01) && off_i[0]) ||
                         ((func3_i[1:0] == 2'b10) && (off_i != 2'b00));
   assign ld_illegal_o = (func3_i == 3'd3) || (func3_i == 3'd6) || (func3_i == 3'd7);
   assign st_illegal_o = (func3_i > 3'd2);

endmodule

// File: rtl/mem_lsu.sv
// RV32I memory stage: accepts from EX, runs one req/gnt/rvalid bus transaction at a time,
// and registers the writeback result, with alignment/legality checks and a watchdog.
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              mem_we_in,
   input  logic              mem_re_in,
   input  logic [ADDR_W-1:0] alu_in,
   input  logic [31:0]       store_data_in,
   input  logic [4:0]        rd_addr_in,
   input  logic              reg_enable_in,
   input  logic [2:0]        func3,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata,
   output logic              wb_valid,
   output logic [31:0]       final_data_out,
   output logic [4:0]        rd_addr_out,
   output logic              reg_enable_out,
   output logic              fault_out
);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;
   logic              ren_q, ren_d;
   logic [31:0]       wd_q, wd_d;
   logic              wb_valid_q, wb_valid_d;
   logic [31:0]       data_q, data_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic              ren_out_q, ren_out_d;
   logic              fault_q, fault_d;

   logic              idle;
   logic [31:0]       al_wdata, al_ldata;
   logic [3:0]        al_be;
   logic              al_mis, al_ld_ill, al_st_ill;
   logic              bad_access, timeout_hit;

   assign idle = (state_q == StIdle);

   // In IDLE the aligner judges the incoming op; afterwards it decodes the latched load.
   mem_lsu_align u_align (
      .func3_i      (idle ? func3 : f3_q),
      .off_i        (idle ? alu_in[1:0] : off_q),
      .store_data_i (store_data_in),
      .rdata_i      (bus_rdata),
      .wdata_o      (al_wdata),
      .be_o         (al_be),
      .ldata_o      (al_ldata),
      .misaligned_o (al_mis),
      .ld_illegal_o (al_ld_ill),
      .st_illegal_o (al_st_ill)
   );

   assign bad_access  = (mem_we_in && mem_re_in) || (mem_we_in ? al_st_ill : al_ld_ill) || al_mis;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (wd_q == TIMEOUT_CYC);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      we_d       = we_q;
      f3_d       = f3_q;
      off_d      = off_q;
      rd_d       = rd_q;
      ren_d      = ren_q;
      wd_d       = wd_q;
      wb_valid_d = 1'b0;
      data_d     = data_q;
      rd_out_d   = rd_out_q;
      ren_out_d  = ren_out_q;
      fault_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ex_valid) begin
               if (!mem_we_in && !mem_re_in) begin
                  wb_valid_d = 1'b1;
                  data_d     = 32'(alu_in);
                  rd_out_d   = rd_addr_in;
                  ren_out_d  = reg_enable_in;
               end else if (bad_access) begin
                  wb_valid_d = 1'b1;
                  fault_d    = 1'b1;
                  rd_out_d   = rd_addr_in;
                  ren_out_d  = 1'b0;
               end else begin
                  addr_d  = alu_in & ~ADDR_W'(3);
                  wdata_d = al_wdata;
                  be_d    = mem_we_in ? al_be : 4'b1111;
                  we_d    = mem_we_in;
                  f3_d    = func3;
                  off_d   = alu_in[1:0];
                  rd_d    = rd_addr_in;
                  ren_d   = reg_enable_in;
                  wd_d    = '0;
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            wd_d = wd_q + 32'd1;
            if (bus_gnt) begin
               if (we_q) begin
                  wb_valid_d = 1'b1;
                  rd_out_d   = rd_q;
                  ren_out_d  = 1'b0;
                  state_d    = StIdle;
               end else begin
                  state_d = StResp;
               end
            end else if (timeout_hit) begin
               wb_valid_d = 1'b1;
               fault_d    = 1'b1;
               rd_out_d   = rd_q;
               ren_out_d  = 1'b0;
               state_d    = StIdle;
            end
         end
         StResp: begin
            wd_d = wd_q + 32'd1;
            if (bus_rvalid) begin
               wb_valid_d = 1'b1;
               data_d     = al_ldata;
               rd_out_d   = rd_q;
               ren_out_d  = ren_q;
               state_d    = StIdle;
            end else if (timeout_hit) begin
               wb_valid_d = 1'b1;
               fault_d    = 1'b1;
               rd_out_d   = rd_q;
               ren_out_d  = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         rd_q       <= '0;
         ren_q      <= 1'b0;
         wd_q       <= '0;
         wb_valid_q <= 1'b0;
         data_q     <= '0;
         rd_out_q   <= '0;
         ren_out_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         rd_q       <= rd_d;
         ren_q      <= ren_d;
         wd_q       <= wd_d;
         wb_valid_q <= wb_valid_d;
         data_q     <= data_d;
         rd_out_q   <= rd_out_d;
         ren_out_q  <= ren_out_d;
         fault_q    <= fault_d;
      end
   end

   assign ex_ready       = idle;
   assign bus_req        = (state_q == StReq);
   assign bus_we         = we_q;
   assign bus_addr       = addr_q;
   assign bus_wdata      = wdata_q;
   assign bus_be         = be_q;
   assign wb_valid       = wb_valid_q;
   assign final_data_out = data_q;
   assign rd_addr_out    = rd_out_q;
   assign reg_enable_out = ren_out_q;
   assign fault_out      = fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: transaction-level model sets per-cycle expectations, a negedge process
// compares them; a second instance with a short watchdog covers the abort path.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, mem_we_in, mem_re_in, reg_enable_in;
   logic [31:0] alu_in, store_data_in, bus_rdata;
   logic [4:0]  rd_addr_in;
   logic [2:0]  func3;
   logic        bus_gnt, bus_rvalid;
   logic        ex_ready, bus_req, bus_we, wb_valid, reg_enable_out, fault_out;
   logic [31:0] bus_addr, bus_wdata, final_data_out;
   logic [3:0]  bus_be;
   logic [4:0]  rd_addr_out;

   logic        t_ex_valid, t_gnt, t_rvalid;
   logic        t_ready, t_req, t_bwe, t_wb, t_reno, t_fault;
   logic [31:0] t_addr, t_wdata, t_final;
   logic [3:0]  t_be;
   logic [4:0]  t_rdo;

   always #5 clk = ~clk;

   mem_lsu #(.ADDR_W(32), .TIMEOUT_CYC(255)) u_dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .mem_we_in(mem_we_in), .mem_re_in(mem_re_in), .alu_in(alu_in),
      .store_data_in(store_data_in), .rd_addr_in(rd_addr_in), .reg_enable_in(reg_enable_in),
      .func3(func3), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .wb_valid(wb_valid), .final_data_out(final_data_out),
      .rd_addr_out(rd_addr_out), .reg_enable_out(reg_enable_out), .fault_out(fault_out)
   );

   mem_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) u_to (
      .clk(clk), .rst(rst), .ex_valid(t_ex_valid), .ex_ready(t_ready),
      .mem_we_in(1'b0), .mem_re_in(1'b1), .alu_in(32'h40),
      .store_data_in(32'h0), .rd_addr_in(5'd9), .reg_enable_in(1'b1),
      .func3(3'b010), .bus_req(t_req), .bus_we(t_bwe), .bus_addr(t_addr),
      .bus_wdata(t_wdata), .bus_be(t_be), .bus_gnt(t_gnt), .bus_rvalid(t_rvalid),
      .bus_rdata(32'hDEADBEEF), .wb_valid(t_wb), .final_data_out(t_final),
      .rd_addr_out(t_rdo), .reg_enable_out(t_reno), .fault_out(t_fault)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic        chk_en = 1'b0;
   logic        e_ready, e_req, e_wb, e_fault, e_ren, e_we, e_chk_wdata, e_final_known;
   logic [4:0]  e_rd;
   logic [31:0] e_addr, e_wdata, e_final;
   logic [3:0]  e_be;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec rules in plain arithmetic.
   function automatic int m_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic m_bad(input logic we, input logic re, input logic [2:0] f3,
                                  input logic [1:0] off);
      if (we && re) return 1'b1;
      if (re && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
      if (we && f3 > 2) return 1'b1;
      return (int'(off) % m_size(f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] r = '0;
      for (int i = 0; i < 4; i++)
         if (i >= int'(off) && i < int'(off) + m_size(f3)) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % m_size(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
      int o = int'(off);
      int v;
      case (f3)
         3'd0: begin v = int'(w[8*o +: 8]);  if (v >= 128) v -= 256; end
         3'd4: v = int'(w[8*o +: 8]);
         3'd1: begin v = int'(w[8*o +: 16]); if (v >= 32768) v -= 65536; end
         3'd5: v = int'(w[8*o +: 16]);
         default: v = int'(w);
      endcase
      return 32'(v);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ex_ready", 32'(ex_ready), 32'(e_ready));
         chk("bus_req", 32'(bus_req), 32'(e_req));
         chk("wb_valid", 32'(wb_valid), 32'(e_wb));
         chk("fault_out", 32'(fault_out), 32'(e_fault));
         if (e_req) begin
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_we", 32'(bus_we), 32'(e_we));
            chk("bus_be", 32'(bus_be), 32'(e_be));
            if (e_chk_wdata) chk("bus_wdata", bus_wdata, e_wdata);
         end
         if (e_wb) chk("reg_enable_out", 32'(reg_enable_out), 32'(e_ren));
         if (e_wb && e_ren) chk("rd_addr_out", 32'(rd_addr_out), 32'(e_rd));
         if (e_final_known) chk("final_data_out", final_data_out, e_final);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      step();
      e_ready = 1'b1; e_req = 1'b0; e_wb = 1'b0; e_fault = 1'b0;
   endtask

   task automatic run_op(input logic we, input logic re, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic ren, input int gw, input int rw,
                         input logic [31:0] rword, input logic noise);
      logic [1:0] off;
      off = addr[1:0];
      ex_valid = 1'b1; mem_we_in = we; mem_re_in = re; func3 = f3; alu_in = addr;
      store_data_in = data; rd_addr_in = rd; reg_enable_in = ren;
      step();
      ex_valid = 1'b0;
      alu_in = $urandom; store_data_in = $urandom;
      func3 = 3'($urandom); rd_addr_in = 5'($urandom);
      e_ready = 1'b1; e_req = 1'b0; e_fault = 1'b0;
      if (!we && !re) begin
         e_wb = 1'b1; e_ren = ren; e_rd = rd; e_final = addr; e_final_known = 1'b1;
      end else if (m_bad(we, re, f3, off)) begin
         e_wb = 1'b1; e_fault = 1'b1; e_ren = 1'b0; e_final_known = 1'b0;
      end else begin
         e_ready = 1'b0; e_req = 1'b1; e_wb = 1'b0;
         e_addr = addr & ~32'h3; e_we = we; e_be = we ? m_be(f3, off) : 4'b1111;
         e_wdata = m_wdata(f3, data); e_chk_wdata = we;
         cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata;
         ex_valid = noise; mem_re_in = noise;
         for (int i = 0; i < gw; i++) begin
            bus_gnt = 1'b0; bus_rvalid = noise; bus_rdata = $urandom;
            step();
         end
         bus_gnt = 1'b1; bus_rvalid = noise; bus_rdata = $urandom;
         step();
         bus_gnt = 1'b0; bus_rvalid = 1'b0;
         e_req = 1'b0;
         if (we) begin
            e_ready = 1'b1; e_wb = 1'b1; e_ren = 1'b0; e_final_known = 1'b0;
         end else begin
            for (int i = 0; i < rw; i++) begin
               bus_gnt = noise;
               step();
            end
            bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rword;
            step();
            bus_rvalid = 1'b0;
            e_ready = 1'b1; e_wb = 1'b1; e_ren = ren; e_rd = rd;
            e_final = m_load(f3, off, rword); e_final_known = 1'b1;
         end
      end
      ex_valid = 1'b0; mem_we_in = 1'b0; mem_re_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ex_valid = 1'b0; mem_we_in = 1'b0; mem_re_in = 1'b0; reg_enable_in = 1'b0;
      alu_in = '0; store_data_in = '0; rd_addr_in = '0; func3 = '0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      t_ex_valid = 1'b0; t_gnt = 1'b0; t_rvalid = 1'b0;
      e_we = 1'b0; e_chk_wdata = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0; e_rd = '0;
      e_ren = 1'b0;
      step();
      e_ready = 1'b1; e_req = 1'b0; e_wb = 1'b0; e_fault = 1'b0;
      e_final = '0; e_final_known = 1'b1;
      chk_en = 1'b1;
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_be", 32'(bus_be), 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_rd_addr_out", 32'(rd_addr_out), 32'h0);
      chk("rst_reg_enable", 32'(reg_enable_out), 32'h0);
      rst = 1'b0;
      idle_cycle();

      // Directed cases with hand-computed values.
      run_op(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd3, 1'b1, 0, 0, 32'h0, 1'b0);
      chk("pass_data", final_data_out, 32'h1234);
      run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'hAB, 5'd4, 1'b1, 3, 0, 32'h0, 1'b0);
      chk("sb_addr", cap_addr, 32'h100);
      chk("sb_be", 32'(cap_be), 32'h8);
      chk("sb_wdata", cap_wdata, 32'hABABABAB);
      chk("sb_ren", 32'(reg_enable_out), 32'h0);
      run_op(1'b0, 1'b1, 3'd0, 32'h201, 32'h0, 5'd5, 1'b1, 0, 4, 32'h80FF7F01, 1'b1);
      chk("lb_off1", final_data_out, 32'h0000007F);
      run_op(1'b0, 1'b1, 3'd0, 32'h203, 32'h0, 5'd6, 1'b1, 1, 4, 32'h80FF7F01, 1'b1);
      chk("lb_off3", final_data_out, 32'hFFFFFF80);
      run_op(1'b0, 1'b1, 3'd5, 32'h202, 32'h0, 5'd7, 1'b1, 0, 4, 32'h80FF7F01, 1'b0);
      chk("lhu_off2", final_data_out, 32'h000080FF);
      run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0, 5'd8, 1'b1, 2, 4, 32'h80FF7F01, 1'b1);
      chk("lh_off2", final_data_out, 32'hFFFF80FF);
      run_op(1'b0, 1'b1, 3'd2, 32'h102, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0);
      chk("lw_mis_fault", 32'(fault_out), 32'h1);
      run_op(1'b1, 1'b0, 3'd1, 32'h101, 32'h55AA, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0);
      chk("sh_mis_fault", 32'(fault_out), 32'h1);
      idle_cycle();

      // Reset during RESP, then a late rvalid, then a normal LW.
      ex_valid = 1'b1; mem_re_in = 1'b1; func3 = 3'd2; alu_in = 32'h300; rd_addr_in = 5'd2;
      reg_enable_in = 1'b1;
      step();
      ex_valid = 1'b0; mem_re_in = 1'b0;
      e_ready = 1'b0; e_req = 1'b1; e_wb = 1'b0; e_addr = 32'h300; e_we = 1'b0;
      e_be = 4'b1111; e_chk_wdata = 1'b0;
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0; e_req = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      e_ready = 1'b1; e_final = '0; e_final_known = 1'b1;
      chk("rstmid_bus_addr", bus_addr, 32'h0);
      chk("rstmid_bus_be", 32'(bus_be), 32'h0);
      chk("rstmid_reg_enable", 32'(reg_enable_out), 32'h0);
      bus_rvalid = 1'b1; bus_gnt = 1'b1; bus_rdata = 32'h12345678;
      idle_cycle();
      bus_rvalid = 1'b0; bus_gnt = 1'b0;
      idle_cycle();
      run_op(1'b0, 1'b1, 3'd2, 32'h304, 32'h0, 5'd11, 1'b1, 1, 1, 32'hCAFEF00D, 1'b0);
      chk("lw_after_rst", final_data_out, 32'hCAFEF00D);

      // Randomized ops, back to back with occasional gaps.
      for (int n = 0; n < 250; n++) begin
         int k;
         logic we, re;
         k = int'($urandom_range(0, 9));
         we = (k >= 6);
         re = (k >= 2 && k <= 5) || (k == 9);
         run_op(we, re, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                1'($urandom));
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();
      chk_en = 1'b0;

      // Watchdog instance: LW whose grant never comes.
      t_ex_valid = 1'b1;
      step();
      t_ex_valid = 1'b0;
      for (int c = 0; c <= 4; c++) begin
         chk("to_req_held", 32'(t_req), 32'h1);
         chk("to_no_wb", 32'(t_wb), 32'h0);
         step();
      end
      chk("to_wb", 32'(t_wb), 32'h1);
      chk("to_fault", 32'(t_fault), 32'h1);
      chk("to_ren", 32'(t_reno), 32'h0);
      chk("to_req_drop", 32'(t_req), 32'h0);
      chk("to_ready", 32'(t_ready), 32'h1);
      t_rvalid = 1'b1;
      step();
      chk("to_pulse_end", 32'(t_wb), 32'h0);
      step();
      t_rvalid = 1'b0;
      chk("to_late_rvalid", 32'(t_wb), 32'h0);
      chk("to_late_fault", 32'(t_fault), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store memory stage for the RV32I core, successor to the single-cycle word-only MEM stage. It sits between EX and WB. It supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte enables and sign/zero extension. It talks to data RAM over a req/gnt/rvalid handshake that tolerates multi-cycle latency, stalls EX while a access is outstanding, flags misaligned or illegal accesses, and registers its WB outputs.

## Interface
- ADDR_W, 32, bus/ALU address width (≥ 2).
- TIMEOUT_CYC, 255, max cycles spent in REQ+RESP before abort. 0 disables the watchdog.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX presents an instruction.
- ex_ready  out  1  stage accepts an instruction (high only in IDLE).
- mem_we_in / mem_re_in  in  1 each  store / load. Both low means pass-through.
- alu_in  in  ADDR_W  effective address or ALU result.
- store_data_in  in  32  rs2 value.
- rd_addr_in  in  5, reg_enable_in  in  1  destination register and write enable.
- func3  in  3  access width/sign.
- bus_req  out  1, bus_we  out  1, bus_addr  out  ADDR_W (bits [1:0]=0), bus_wdata  out  32, bus_be  out  4.
- bus_gnt  in  1  request accepted. bus_rvalid  in  1, bus_rdata  in  32  read response.
- wb_valid  out  1, final_data_out  out  32, rd_addr_out  out  5, reg_enable_out  out  1.
- fault_out  out  1  one-cycle pulse alongside wb_valid for misaligned, illegal func3 or timeout.

## Operation
- FSM states: IDLE, REQ, RESP. Reset → IDLE.
- IDLE, ex_valid high:
  - If neither mem_we_in nor mem_re_in is set, the ALU result is registered to WB: final_data_out=alu_in, wb_valid=1 next cycle.
  - If the access is legal and aligned, address, data, func3, rd and we/re are latched and the FSM goes to REQ.
  - If the access is illegal or misaligned: no bus access; next cycle wb_valid=1, fault_out=1, reg_enable_out=0. FSM stays in IDLE.
- Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- Illegal means: load func3 of 3, 6 or 7; store func3 greater than 2.
- Both mem_we_in and mem_re_in set is treated as illegal.
- REQ: bus_req=1 and bus signals are driven from the latched values, held stable until bus_gnt.
  - On gnt with a store: WB pulse with reg_enable_out=0, then IDLE.
  - On gnt with a load: go to RESP.
- RESP: on bus_rvalid, load the extended data into final_data_out, reg_enable_out=latched value, wb_valid=1, then IDLE.
- Store lanes, with off=addr[1:0]:
  - SB: wdata={4{b}}, be=0001<<off.
  - SH: wdata={2{h}}, be=0011<<off.
  - SW: be=1111.
  - Loads drive be=1111 and bus_we=0.
- Load extraction: lane=rdata>>(8·off).
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes rdata unchanged.
- Watchdog: a counter clears on entry to REQ and increments in REQ/RESP. If it reaches TIMEOUT_CYC before completion: go to IDLE, fault pulse, reg_enable_out=0, bus_req drops.

## Timing
- Reset values: all outputs 0 and ex_ready=1 (FSM in IDLE). bus_addr/wdata/be are 0.
- Pass-through and fault latency: 1 cycle, accept edge to wb_valid.
- Store latency: 1 cycle in REQ plus one cycle per gnt wait. wb_valid is asserted the cycle after gnt.
- Load latency: minimum 3 cycles (accept → REQ → gnt → RESP → rvalid → wb_valid). bus_rvalid is ignored outside RESP, including a rvalid in the same cycle as gnt.
- wb_valid is a one-cycle pulse. WB data outputs hold their values until the next wb_valid.
- ex_ready is low throughout REQ/RESP, so back-to-back memory ops are separated by the full transaction.
- Reset mid-transaction: bus_req is 0 from the cycle after the reset edge. A late rvalid/gnt is ignored.
- Timeout with TIMEOUT_CYC=N: the abort WB pulse occurs N+1 cycles after entering REQ.

## Structure
- define.v gains INST_LB/LH/LBU/LHU/SB/SH/SW alongside the existing INST_LW. FSM state encodings stay local.
- One combinational sub-module, lsu_align:
  - inputs: func3, off, store data, rdata.
  - outputs: bus_wdata, bus_be, extended load data, misaligned/illegal flags.
- The top level holds the FSM, latches, watchdog and WB registers.

## Test plan
- ALU pass-through: alu_in=0x1234, no re/we → wb_valid next cycle, final_data_out=0x1234, no bus_req.
- SB to 0x103, data 0xAB: bus_addr=0x100, be=1000, wdata=0xABABABAB, held across 3 gnt-low cycles → WB pulse after gnt, reg_enable_out=0.
- Loads from word 0x80FF7F01:
  - LB off=1 → 0x0000007F.
  - LB off=3 → 0xFFFFFF80.
  - LHU off=2 → 0x000080FF.
  - LH off=2 → 0xFFFF80FF.
  - rvalid asserted 4 cycles after gnt.
- LW to 0x102 and SH to 0x101 → no bus_req, fault_out=1, reg_enable_out=0, ex_ready stays 1.
- TIMEOUT_CYC=4, gnt never asserted → abort with fault at cycle 5 after REQ entry. A subsequent rvalid is ignored.
- rst asserted during RESP → IDLE, all outputs 0 next cycle. The following LW completes normally.
